// File: rtl/axi_ar_decoder_ordered.sv
`default_nettype none
// ============================================================================
// Module   : axi_ar_decoder_ordered
// Brief    : AR-channel decoder with fixed-priority routing, in-order
//            outstanding tracking and unmapped-address drain/error hand-off.
//            Optional default target: AXI_AR_DECODER_DEFAULT_SLAVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ar_decoder_ordered #(
    parameter int ADDR_WIDTH      = 32,
    parameter int N_INIT_PORT     = 8,
    parameter int N_REGION        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int PORT_W          = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   arvalid_i,
    input  logic [ADDR_WIDTH-1:0]                                  araddr_i,
    output logic                                                   arready_o,
    output logic [N_INIT_PORT-1:0]                                 arvalid_o,
    input  logic [N_INIT_PORT-1:0]                                 arready_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   START_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   END_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                   enable_region_i,
    input  logic [N_INIT_PORT-1:0]                                 connectivity_map_i,
    input  logic                                                   r_done_i,
    output logic                                                   error_req_o,
    input  logic                                                   error_gnt_i,
    output logic                                                   sample_ardata_info_o,
    output logic [CNT_W-1:0]                                       outstanding_o
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
    ,
    input  logic [PORT_W-1:0]                                      default_port_i
`endif
);

    localparam logic [1:0] c_ST_OPERATIVE = 2'd0;
    localparam logic [1:0] c_ST_DRAIN     = 2'd1;
    localparam logic [1:0] c_ST_ERR_REQ   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PORT_W-1:0]      last_q, last_d;

    logic [N_INIT_PORT-1:0] w_match;
    logic [N_INIT_PORT-1:0] w_sel;
    logic                   w_hit_any;
    logic [PORT_W-1:0]      w_target;
    logic                   w_route_valid;
    logic [PORT_W-1:0]      w_route_port;
    logic                   w_permit;
    logic                   w_miss_accept;
    logic                   w_mst_hs;
    logic                   w_inc;
    logic                   w_dec;

    // ------------------------------------------------------------------
    // Address decode: a port matches when any enabled region window hits
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_port
            logic [N_REGION-1:0] w_hit;
            for (genvar r = 0; r < N_REGION; r++) begin : g_region
                assign w_hit[r] = enable_region_i[r][p]
                               && (araddr_i >= START_ADDR_i[r][p])
                               && (araddr_i <= END_ADDR_i[r][p]);
            end
            assign w_match[p] = connectivity_map_i[p] && (|w_hit);
        end
    endgenerate

    // Lowest index wins: scan downward so the last assignment is the lowest
    always_comb begin
        w_hit_any = 1'b0;
        w_target  = '0;
        for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
            if (w_match[p]) begin
                w_hit_any = 1'b1;
                w_target  = PORT_W'(p);
            end
        end
    end

`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
    logic w_dflt_ok;

    always_comb begin
        w_dflt_ok = 1'b0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            if ((PORT_W'(p) == default_port_i) && connectivity_map_i[p]) begin
                w_dflt_ok = 1'b1;
            end
        end
    end

    assign w_route_valid = w_hit_any | w_dflt_ok;
    assign w_route_port  = w_hit_any ? w_target : default_port_i;
`else
    assign w_route_valid = w_hit_any;
    assign w_route_port  = w_target;
`endif

    generate
        for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_sel
            assign w_sel[p] = (w_route_port == PORT_W'(p));
        end
    endgenerate

    // Switching target only once every earlier burst has returned
    assign w_permit = ((cnt_q == '0) || (w_route_port == last_q))
                   && (cnt_q < CNT_W'(MAX_OUTSTANDING));

    assign w_miss_accept = rst_n && (state_q == c_ST_OPERATIVE)
                        && arvalid_i && !w_route_valid;

    assign w_mst_hs = |(arvalid_o & arready_i);
    assign w_inc    = w_mst_hs;
    assign w_dec    = r_done_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (w_inc && !w_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign last_d = w_mst_hs ? w_route_port : last_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_ST_OPERATIVE;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (drain exit looks at the post-update count)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_OPERATIVE: begin
                if (w_miss_accept) begin
                    state_d = (cnt_d == '0) ? c_ST_ERR_REQ : c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = c_ST_ERR_REQ;
                end
            end
            c_ST_ERR_REQ: begin
                if (error_gnt_i) begin
                    state_d = c_ST_OPERATIVE;
                end
            end
            default: state_d = c_ST_OPERATIVE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, all forced low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        arready_o            = 1'b0;
        arvalid_o            = '0;
        error_req_o          = 1'b0;
        sample_ardata_info_o = 1'b0;
        if (rst_n) begin
            case (state_q)
                c_ST_OPERATIVE: begin
                    if (w_route_valid) begin
                        if (w_permit) begin
                            arvalid_o = w_sel & {N_INIT_PORT{arvalid_i}};
                            arready_o = arready_i[w_route_port];
                        end
                    end else if (arvalid_i) begin
                        arready_o            = 1'b1;
                        sample_ardata_info_o = 1'b1;
                    end
                end
                c_ST_ERR_REQ: begin
                    error_req_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign outstanding_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_decoder_ordered.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ar_decoder_ordered
// Brief    : Self-checking bench for axi_ar_decoder_ordered, directed
//            scenarios plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ar_decoder_ordered;

    localparam int AW  = 32;
    localparam int NP  = 8;
    localparam int NR  = 4;
    localparam int MO  = 8;
    localparam int CW  = $clog2(MO + 1);
    localparam int PW  = $clog2(NP);
    localparam int VW  = 1 + NP + 1 + 1 + CW;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          arvalid_i;
    logic [AW-1:0]                 araddr_i;
    logic                          arready_o;
    logic [NP-1:0]                 arvalid_o;
    logic [NP-1:0]                 arready_i;
    logic [NR-1:0][NP-1:0][AW-1:0] st;
    logic [NR-1:0][NP-1:0][AW-1:0] ea;
    logic [NR-1:0][NP-1:0]         en;
    logic [NP-1:0]                 conn;
    logic                          r_done;
    logic                          error_req_o;
    logic                          gnt;
    logic                          sample_o;
    logic [CW-1:0]                 outstanding_o;
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
    logic [PW-1:0]                 dflt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // behavioural model state
    int      m_cnt, m_last;
    bit      m_waiting, m_err;
    logic    e_arready, e_err, e_sample;
    logic [NP-1:0] e_arvalid;
    bit      e_hs, e_miss;
    int      e_t;
    logic [VW-1:0] obs, expv;

    axi_ar_decoder_ordered dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .arvalid_i            (arvalid_i),
        .araddr_i             (araddr_i),
        .arready_o            (arready_o),
        .arvalid_o            (arvalid_o),
        .arready_i            (arready_i),
        .START_ADDR_i         (st),
        .END_ADDR_i           (ea),
        .enable_region_i      (en),
        .connectivity_map_i   (conn),
        .r_done_i             (r_done),
        .error_req_o          (error_req_o),
        .error_gnt_i          (gnt),
        .sample_ardata_info_o (sample_o),
        .outstanding_o        (outstanding_o)
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
        ,
        .default_port_i       (dflt)
`endif
    );

    always #5 clk = ~clk;

    // Which port should take araddr_i: first connected port with a hit
    function automatic int ref_target();
        int res = -1;
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < NR; r++) begin
                if (res < 0 && conn[p] && en[r][p] && araddr_i >= st[r][p] && araddr_i <= ea[r][p])
                    res = p;
            end
        end
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
        if (res < 0 && int'(dflt) < NP && conn[dflt]) res = int'(dflt);
`endif
        return res;
    endfunction

    function automatic void model_eval();
        e_arready = 1'b0; e_arvalid = '0; e_err = 1'b0; e_sample = 1'b0;
        e_hs = 1'b0; e_miss = 1'b0; e_t = ref_target();
        if (!rst_n) begin
        end else if (m_err) begin
            e_err = 1'b1;
        end else if (m_waiting) begin
        end else if (e_t >= 0) begin
            if ((m_cnt == 0 || e_t == m_last) && m_cnt < MO) begin
                e_arvalid[e_t] = arvalid_i;
                e_arready      = arready_i[e_t];
                e_hs           = arvalid_i && arready_i[e_t];
            end
        end else if (arvalid_i) begin
            e_arready = 1'b1; e_sample = 1'b1; e_miss = 1'b1;
        end
    endfunction

    function automatic void model_tick();
        int nc;
        if (!rst_n) begin
            m_cnt = 0; m_last = 0; m_waiting = 0; m_err = 0;
        end else begin
            nc = m_cnt + (e_hs ? 1 : 0) - ((r_done && m_cnt > 0) ? 1 : 0);
            if (e_hs) m_last = e_t;
            if (m_err) begin
                if (gnt) m_err = 0;
            end else if (m_waiting || e_miss) begin
                if (nc == 0) begin m_waiting = 0; m_err = 1; end
                else m_waiting = 1;
            end
            m_cnt = nc;
        end
    endfunction

    task automatic idle_inputs();
        arvalid_i = 1'b0; araddr_i = '0; arready_i = '1;
        r_done = 1'b0; gnt = 1'b0; rst_n = 1'b1;
    endtask

    task automatic clear_map();
        st = '0; ea = '0; en = '0; conn = '1;
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
        dflt = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); model_tick(); #1;
        rst_n = 1'b1;
    endtask

    task automatic map_port(input int r, input int p, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        st[r][p] = lo; ea[r][p] = hi; en[r][p] = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs(); clear_map(); map_port(0, 0, 32'h0, 32'h0FFF);
        for (int c = 0; c < 3; c++) begin
            rst_n = (c != 0); arvalid_i = 1'b1; araddr_i = 32'h10;
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL reset c%0d got %h expected %h", c, obs, expv); end
            if (c == 0) begin
                n_vec++;
                if ({arready_o, arvalid_o} !== '0) begin n_miss++; $display("FAIL reset_outputs got %b expected 0", {arready_o, arvalid_o}); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_priority();
        do_reset(); clear_map();
        map_port(0, 1, 32'h1000, 32'h1FFF);
        map_port(0, 3, 32'h1000, 32'h1FFF);
        for (int c = 0; c < 3; c++) begin
            arvalid_i = (c == 0); araddr_i = 32'h1800;
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL priority c%0d got %h expected %h", c, obs, expv); end
            if (c == 0) begin
                n_vec++;
                if (arvalid_o !== 8'b0000_0010) begin n_miss++; $display("FAIL priority_onehot got %b expected 00000010", arvalid_o); end
            end
            if (c == 1) begin
                n_vec++;
                if (outstanding_o !== CW'(1)) begin n_miss++; $display("FAIL priority_cnt got %0d expected 1", outstanding_o); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_ordering_stall();
        do_reset(); clear_map();
        map_port(0, 1, 32'h1000, 32'h1FFF);
        map_port(0, 2, 32'h2000, 32'h2FFF);
        for (int c = 0; c < 7; c++) begin
            arvalid_i = (c != 6);
            araddr_i  = (c < 2) ? 32'h1100 : 32'h2000;
            r_done    = (c == 3 || c == 4);
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL ordering c%0d got %h expected %h", c, obs, expv); end
            if (c == 2) begin
                n_vec++;
                if ({arready_o, arvalid_o} !== '0) begin n_miss++; $display("FAIL ordering_stall got %b expected 0", {arready_o, arvalid_o}); end
            end
            if (c == 5) begin
                n_vec++;
                if (arvalid_o !== 8'b0000_0100) begin n_miss++; $display("FAIL ordering_issue got %b expected 00000100", arvalid_o); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_saturation();
        do_reset(); clear_map();
        map_port(0, 0, 32'h0, 32'h0FFF);
        for (int c = 0; c < 12; c++) begin
            arvalid_i = (c != 11); araddr_i = 32'h10; r_done = (c == 9);
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL saturation c%0d got %h expected %h", c, obs, expv); end
            if (c == 8) begin
                n_vec++;
                if ({outstanding_o, arvalid_o} !== {CW'(8), 8'h00}) begin n_miss++; $display("FAIL saturation_stall got %h expected %h", {outstanding_o, arvalid_o}, {CW'(8), 8'h00}); end
            end
            if (c == 11) begin
                n_vec++;
                if (outstanding_o !== CW'(8)) begin n_miss++; $display("FAIL saturation_cnt got %0d expected 8", outstanding_o); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_miss_drain();
        do_reset(); clear_map();
        map_port(0, 0, 32'h0, 32'h0FFF);
        for (int c = 0; c < 11; c++) begin
            arvalid_i = 1'b1;
            araddr_i  = (c == 3) ? 32'hF000_0000 : 32'h10;
            r_done    = (c >= 4 && c <= 6);
            gnt       = (c == 8);
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL miss_drain c%0d got %h expected %h", c, obs, expv); end
            if (c == 3) begin
                n_vec++;
                if ({arready_o, sample_o, arvalid_o} !== {2'b11, 8'h00}) begin n_miss++; $display("FAIL miss_accept got %b expected 1100000000", {arready_o, sample_o, arvalid_o}); end
            end
            if (c == 7) begin
                n_vec++;
                if ({error_req_o, arready_o} !== 2'b10) begin n_miss++; $display("FAIL miss_errreq got %b expected 10", {error_req_o, arready_o}); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_simultaneous_reset();
        do_reset(); clear_map();
        map_port(0, 0, 32'h0, 32'h0FFF);
        for (int c = 0; c < 9; c++) begin
            arvalid_i = (c != 7);
            araddr_i  = (c == 6) ? 32'hF000_0000 : 32'h10;
            r_done    = (c == 1);
            rst_n     = (c != 7);
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL simul_reset c%0d got %h expected %h", c, obs, expv); end
            if (c == 2) begin
                n_vec++;
                if (outstanding_o !== CW'(1)) begin n_miss++; $display("FAIL simul_cnt got %0d expected 1", outstanding_o); end
            end
            if (c == 7) begin
                n_vec++;
                if ({arready_o, arvalid_o, error_req_o, sample_o, outstanding_o} !== {11'b0, CW'(5)}) begin n_miss++; $display("FAIL reset_in_drain got %h expected %h", {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o}, {11'b0, CW'(5)}); end
            end
            if (c == 8) begin
                n_vec++;
                if ({outstanding_o, arvalid_o} !== {CW'(0), 8'h01}) begin n_miss++; $display("FAIL after_reset got %h expected %h", {outstanding_o, arvalid_o}, {CW'(0), 8'h01}); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
    task automatic test_default_port();
        do_reset(); clear_map();
        map_port(0, 0, 32'h0, 32'h0FFF);
        dflt = PW'(4);
        for (int c = 0; c < 8; c++) begin
            conn      = (c >= 3) ? 8'b1110_1111 : 8'hFF;
            arvalid_i = (c == 0 || c == 3);
            araddr_i  = 32'hF000_0000;
            r_done    = (c == 1 || c == 4);
            gnt       = (c == 6);
            @(negedge clk); model_eval();
            obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
            expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
            n_vec++;
            if (obs !== expv) begin n_miss++; $display("FAIL default_port c%0d got %h expected %h", c, obs, expv); end
            if (c == 0) begin
                n_vec++;
                if ({arvalid_o, error_req_o} !== {8'b0001_0000, 1'b0}) begin n_miss++; $display("FAIL default_route got %b expected 000100000", {arvalid_o, error_req_o}); end
            end
            if (c == 5) begin
                n_vec++;
                if (error_req_o !== 1'b1) begin n_miss++; $display("FAIL default_disc got %b expected 1", error_req_o); end
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask
`endif

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            do_reset(); clear_map();
            for (int p = 0; p < NP; p++) begin
                conn[p] = ($urandom_range(0, 99) < 85);
                for (int r = 0; r < NR; r++) begin
                    st[r][p] = AW'($urandom_range(0, 32'hFFFF));
                    ea[r][p] = st[r][p] + AW'($urandom_range(0, 32'h1FFF));
                    en[r][p] = $urandom_range(0, 1);
                end
            end
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
            dflt = PW'($urandom_range(0, NP - 1));
`endif
            for (int c = 0; c < 600; c++) begin
                arvalid_i = ($urandom_range(0, 99) < 70);
                araddr_i  = AW'($urandom_range(0, 32'h11FFF));
                arready_i = NP'($urandom | $urandom);
                r_done    = ($urandom_range(0, 99) < 30);
                gnt       = $urandom_range(0, 1);
                rst_n     = ($urandom_range(0, 299) != 0);
                @(negedge clk); model_eval();
                obs  = {arready_o, arvalid_o, error_req_o, sample_o, outstanding_o};
                expv = {e_arready, e_arvalid, e_err, e_sample, CW'(m_cnt)};
                n_vec++;
                if (obs !== expv) begin n_miss++; $display("FAIL random e%0d c%0d got %h expected %h", ep, c, obs, expv); end
                @(posedge clk); model_tick(); #1;
            end
        end
    endtask

    initial begin
        idle_inputs(); clear_map();
        do_reset();
        test_reset();
        test_priority();
        test_ordering_stall();
        test_saturation();
        test_miss_drain();
        test_simultaneous_reset();
`ifdef AXI_AR_DECODER_DEFAULT_SLAVE_EN
        test_default_port();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
